time_display_scanner: RTL and testbench

- Downstream consumer of the elapsed-time counter and the track index.
- Converts binary `minute`, `second` and `track` to BCD with one shared sequential double-dabble engine.
- Drives the board's 8-digit common-anode seven-segment display: time multiplexed, active-low.
- Displays track number on digits 7–6, blanks 5–4, shows MM.SS on digits 3–0, with the decimal point on digit 2.

---
 rtl/time_display_scanner.sv | 192 +++++++++++++++++++
 tb/tb_time_display_scanner.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_scanner.sv
// Shares one double-dabble engine over track/minute/second and time-multiplexes an 8-digit active-low display.
// Result registers refresh every 33 cycles; an/seg are registered one cycle after the scan index; no backpressure.
module time_display_scanner #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] track,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_STORE} conv_state_t;
  typedef enum logic [1:0] {FLD_TRACK, FLD_MINUTE, FLD_SECOND} field_t;

  conv_state_t state, state_nxt;
  field_t      field;
  logic        load_en, shift_en, store_en;

  logic [7:0]  field_bin;
  logic [7:0]  bin_sr;
  logic [11:0] bcd_acc;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic [2:0]  shift_cnt;

  logic [7:0]  trk_bcd, min_bcd, sec_bcd;
  logic        trk_ovr, min_ovr, sec_ovr;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;
  logic [7:0]       an_nxt, seg_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Converter FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Converter FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (shift_cnt == 3'd7) state_nxt = ST_STORE;
      ST_STORE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Converter FSM: outputs
  always_comb begin
    load_en  = (state == ST_LOAD);
    shift_en = (state == ST_SHIFT);
    store_en = (state == ST_STORE);
  end

  always_comb begin
    case (field)
      FLD_MINUTE: field_bin = minute;
      FLD_SECOND: field_bin = second;
      default:    field_bin = track;
    endcase
  end

  // Add-3 correction on every nibble, then shift the joined {bcd, bin} word
  always_comb begin
    bcd_adj[3:0]  = (bcd_acc[3:0]  >= 4'd5) ? bcd_acc[3:0]  + 4'd3 : bcd_acc[3:0];
    bcd_adj[7:4]  = (bcd_acc[7:4]  >= 4'd5) ? bcd_acc[7:4]  + 4'd3 : bcd_acc[7:4];
    bcd_adj[11:8] = (bcd_acc[11:8] >= 4'd5) ? bcd_acc[11:8] + 4'd3 : bcd_acc[11:8];
    shifted       = {bcd_adj, bin_sr} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr    <= '0;
      bcd_acc   <= '0;
      shift_cnt <= '0;
    end else if (load_en) begin
      bin_sr    <= field_bin;
      bcd_acc   <= '0;
      shift_cnt <= '0;
    end else if (shift_en) begin
      bcd_acc   <= shifted[19:8];
      bin_sr    <= shifted[7:0];
      shift_cnt <= shift_cnt + 3'd1;
    end
  end

  // Each field's digits and over-range flag change together, only here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field   <= FLD_TRACK;
      trk_bcd <= '0;
      min_bcd <= '0;
      sec_bcd <= '0;
      trk_ovr <= 1'b0;
      min_ovr <= 1'b0;
      sec_ovr <= 1'b0;
    end else if (store_en) begin
      case (field)
        FLD_MINUTE: begin
          min_bcd <= bcd_acc[7:0];
          min_ovr <= (bcd_acc[11:8] != 4'd0);
          field   <= FLD_SECOND;
        end
        FLD_SECOND: begin
          sec_bcd <= bcd_acc[7:0];
          sec_ovr <= (bcd_acc[11:8] != 4'd0);
          field   <= FLD_TRACK;
        end
        default: begin
          trk_bcd <= bcd_acc[7:0];
          trk_ovr <= (bcd_acc[11:8] != 4'd0);
          field   <= FLD_MINUTE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    an_nxt  = ~(8'd1 << scan_idx);
    seg_nxt = SEG_BLANK;
    case (scan_idx)
      3'd0: seg_nxt = sec_ovr ? SEG_DASH : seg7(sec_bcd[3:0]);
      3'd1: seg_nxt = sec_ovr ? SEG_DASH : seg7(sec_bcd[7:4]);
      3'd2: seg_nxt = (min_ovr ? SEG_DASH : seg7(min_bcd[3:0])) & 8'h7F;
      3'd3: seg_nxt = min_ovr ? SEG_DASH : seg7(min_bcd[7:4]);
      3'd6: seg_nxt = trk_ovr ? SEG_DASH : seg7(trk_bcd[3:0]);
      3'd7: begin
        // Leading zero of the track number is suppressed
        if (!trk_ovr && trk_bcd[7:4] == 4'd0) begin
          an_nxt  = 8'hFF;
          seg_nxt = SEG_BLANK;
        end else begin
          seg_nxt = trk_ovr ? SEG_DASH : seg7(trk_bcd[7:4]);
        end
      end
      default: begin
        an_nxt  = 8'hFF;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_scanner.sv
// Scoreboarded bench for time_display_scanner with a short scan divider.
module tb_time_display_scanner;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] track = 8'd0;
  logic [7:0] minute = 8'd0;
  logic [7:0] second = 8'd0;
  logic [7:0] an;
  logic [7:0] seg;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  logic [7:0] fr_an [8];
  logic [7:0] fr_seg [8];

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  time_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .track  (track),
    .minute (minute),
    .second (second),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the converter is phase-locked to this count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model_digit(input int d, input int tr, input int mi, input int se);
    exp_t e;
    int   v;
    bit   ovr;
    e.an  = 8'hFF;
    e.seg = 8'hFF;
    v     = 0;
    ovr   = 1'b0;
    case (d)
      0: begin ovr = (se > 99); v = se % 10; end
      1: begin ovr = (se > 99); v = (se / 10) % 10; end
      2: begin ovr = (mi > 99); v = mi % 10; end
      3: begin ovr = (mi > 99); v = (mi / 10) % 10; end
      6: begin ovr = (tr > 99); v = tr % 10; end
      7: begin ovr = (tr > 99); v = (tr / 10) % 10; end
      default: return e;
    endcase
    if (d == 7 && !ovr && v == 0) return e;
    e.an  = ~(8'h01 << d);
    e.seg = ovr ? 8'hBF : SEG_TAB[v];
    if (d == 2) e.seg[7] = 1'b0;
    return e;
  endfunction

  task automatic push_frame(input int tr, input int mi, input int se);
    for (int d = 0; d < 8; d++) sb.push_back(model_digit(d, tr, mi, se));
  endtask

  // Leaves the caller at the first falling edge of a digit-0 slot
  task automatic sync_digit0(output bit ok);
    logic [7:0] prev;
    prev = an;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an == 8'hFE && prev != 8'hFE) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  task automatic grab_frame();
    bit ok;
    int idx;
    for (int d = 0; d < 8; d++) begin
      fr_an[d]  = 8'hxx;
      fr_seg[d] = 8'hxx;
    end
    sync_digit0(ok);
    if (ok) begin
      idx = 0;
      for (int d = 0; d < 8; d++) begin
        while (idx < SCAN_DIV * d + 1) begin
          @(negedge clk);
          idx++;
        end
        fr_an[d]  = an;
        fr_seg[d] = seg;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n  = 1'b0;
    track  = 8'd0;
    minute = 8'd0;
    second = 8'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_hold an=%h seg=%h required an=ff seg=ff", an, seg);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 8'hFE || seg !== 8'hC0) begin
      failures++;
      $display("FAIL reset_first_edge an=%h seg=%h required an=fe seg=c0", an, seg);
    end
    push_frame(0, 0, 0);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL reset_frame digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
  endtask

  task automatic test_normal_display();
    exp_t e;
    track  = 8'd7;
    minute = 8'd3;
    second = 8'd25;
    repeat (70) @(negedge clk);
    push_frame(7, 3, 25);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL normal digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
  endtask

  task automatic test_scan_timing();
    bit   ok;
    exp_t e;
    for (int i = 0; i <= 8 * SCAN_DIV; i++)
      sb.push_back(model_digit((i / SCAN_DIV) % 8, 7, 3, 25));
    sync_digit0(ok);
    for (int i = 0; i <= 8 * SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (!ok || an !== e.an) begin
        failures++;
        $display("FAIL scan_timing cycle%0d an=%h required an=%h", i, an, e.an);
      end
    end
  endtask

  task automatic test_over_range();
    exp_t e;
    minute = 8'd120;
    repeat (70) @(negedge clk);
    push_frame(7, 120, 25);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL over_range digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
    minute = 8'd0;
    repeat (70) @(negedge clk);
    push_frame(7, 0, 25);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL over_range_clear digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
  endtask

  task automatic test_boundaries();
    exp_t e;
    track  = 8'd99;
    minute = 8'd59;
    second = 8'd100;
    repeat (70) @(negedge clk);
    push_frame(99, 59, 100);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL bound_99_100 digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
    track  = 8'd150;
    second = 8'd99;
    repeat (70) @(negedge clk);
    push_frame(150, 59, 99);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL bound_track_ovr digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
    track  = 8'd7;
    minute = 8'd3;
    second = 8'd25;
    repeat (70) @(negedge clk);
  endtask

  task automatic test_mid_conversion();
    exp_t e;
    bit   hit;
    int   bad;
    logic [7:0] s;
    second = 8'd59;
    repeat (70) @(negedge clk);
    push_frame(7, 3, 59);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL mid_conv_pre digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
    // Minute occupies sweep cycles 11..21; its SHIFT phase follows edge 13
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc % 33 == 16) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_conv_window found=%0d required=1", hit);
    end
    second = 8'd0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      s = seg | 8'h80;
      if (!(s inside {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF, 8'hFF}))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_conv_legal_seg illegal_samples=%0d required=0", bad);
    end
    push_frame(7, 3, 0);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL mid_conv_post digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit   ok;
    bit   hit;
    int   idx;
    exp_t e;
    sync_digit0(ok);
    hit = 1'b0;
    idx = 0;
    if (ok) begin
      while (idx < 5 * SCAN_DIV) begin
        @(negedge clk);
        idx++;
      end
      // Slot 5 spans four falling edges; any four consecutive sweep phases meet a SHIFT window
      for (int k = 0; k < SCAN_DIV; k++) begin
        if (cyc % 11 >= 2 && cyc % 11 <= 9) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_mid_window found=%0d required=1", hit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF) begin
      failures++;
      $display("FAIL rst_mid_async an=%h seg=%h required an=ff seg=ff", an, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 8'hFE || seg !== 8'hC0) begin
      failures++;
      $display("FAIL rst_mid_restart an=%h seg=%h required an=fe seg=c0", an, seg);
    end
    repeat (70) @(negedge clk);
    push_frame(7, 3, 0);
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      checks++;
      if (fr_an[d] !== e.an || fr_seg[d] !== e.seg) begin
        failures++;
        $display("FAIL rst_mid_frame digit%0d an=%h seg=%h required an=%h seg=%h", d, fr_an[d], fr_seg[d], e.an, e.seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_display();
    test_scan_timing();
    test_over_range();
    test_boundaries();
    test_mid_conversion();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
